writeback_stage: RTL and testbench

Write-back end of the multicycle datapath. It shares the 10-phase instruction sequence used by the operand-select stage. It samples the ALU result, memory read data or PC+4 late in the instruction, then issues a single-cycle register-file write strobe. It also keeps a forwarding record of the last committed write and a retired-instruction counter.

---
 rtl/writeback_stage_if.sv | 34 +++
 rtl/writeback_stage.sv | 93 +++++++++
 tb/tb_writeback_stage.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/writeback_stage_if.sv
// writeback_stage_if: bundles the write-back stage's instruction inputs and
// its register-file / forwarding / status outputs.
//   regWrite, memToReg, aluResult, memReadData, pcPlus4, rd : per-instruction inputs
//   wbEnable, wbAddr, wbData     : register-file write port
//   fwdValid, fwdAddr, fwdData   : record of the last committed write
//   retired                      : completed-instruction count
//   phase                        : current phase within the instruction
// master drives the inputs and observes the outputs; slave is the stage itself.
interface writeback_stage_if;
   logic        regWrite;
   logic [1:0]  memToReg;
   logic [31:0] aluResult;
   logic [31:0] memReadData;
   logic [31:0] pcPlus4;
   logic [4:0]  rd;
   logic        wbEnable;
   logic [4:0]  wbAddr;
   logic [31:0] wbData;
   logic        fwdValid;
   logic [4:0]  fwdAddr;
   logic [31:0] fwdData;
   logic [31:0] retired;
   logic [3:0]  phase;

   modport master (
      output regWrite, memToReg, aluResult, memReadData, pcPlus4, rd,
      input  wbEnable, wbAddr, wbData, fwdValid, fwdAddr, fwdData, retired, phase
   );

   modport slave (
      input  regWrite, memToReg, aluResult, memReadData, pcPlus4, rd,
      output wbEnable, wbAddr, wbData, fwdValid, fwdAddr, fwdData, retired, phase
   );
endinterface

// File: rtl/writeback_stage.sv
// writeback_stage: write-back end of the multicycle datapath.
// Each instruction takes PHASES cycles. At the CAPTURE_PHASE edge the selected
// source (ALU result, memory read data or PC+4), rd and regWrite are sampled;
// at the COMMIT_PHASE edge a one-cycle register-file write strobe is issued,
// the forwarding record is updated and the retired counter advances.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous, active-low reset
//   bus   : writeback_stage_if.slave (instruction inputs, write port, status)
module writeback_stage #(
   parameter int unsigned PHASES        = 10,
   parameter int unsigned CAPTURE_PHASE = 8,
   parameter int unsigned COMMIT_PHASE  = 9
) (
   input logic              clock,
   input logic              reset,
   writeback_stage_if.slave bus
);

   logic [3:0]  phase_q;
   logic        cap_reg_write;
   logic [4:0]  cap_rd;
   logic [31:0] cap_data;
   logic        wb_enable;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        fwd_valid;
   logic [4:0]  fwd_addr;
   logic [31:0] fwd_data;
   logic [31:0] retired_count;
   logic [31:0] src_data;
   logic        commit_en;

   always_comb begin
      src_data = bus.aluResult;
      unique case (bus.memToReg)
         2'b01:   src_data = bus.memReadData;
         2'b10:   src_data = bus.pcPlus4;
         default: src_data = bus.aluResult;
      endcase
   end

   // Writes to x0 are dropped but still count as retired.
   assign commit_en = cap_reg_write && (cap_rd != 5'd0);

   always_ff @(posedge clock) begin
      if (!reset) begin
         phase_q       <= '0;
         cap_reg_write <= 1'b0;
         cap_rd        <= '0;
         cap_data      <= '0;
         wb_enable     <= 1'b0;
         wb_addr       <= '0;
         wb_data       <= '0;
         fwd_valid     <= 1'b0;
         fwd_addr      <= '0;
         fwd_data      <= '0;
         retired_count <= '0;
      end else begin
         phase_q   <= (phase_q == 4'(PHASES - 1)) ? '0 : phase_q + 4'd1;
         // Strobe defaults low so it lasts exactly one cycle after commit.
         wb_enable <= 1'b0;

         if (phase_q == 4'(CAPTURE_PHASE)) begin
            cap_data      <= src_data;
            cap_rd        <= bus.rd;
            cap_reg_write <= bus.regWrite;
         end

         if (phase_q == 4'(COMMIT_PHASE)) begin
            wb_enable     <= commit_en;
            wb_addr       <= cap_rd;
            wb_data       <= cap_data;
            retired_count <= retired_count + 32'd1;
            fwd_valid     <= commit_en;
            if (commit_en) begin
               fwd_addr <= cap_rd;
               fwd_data <= cap_data;
            end
         end
      end
   end

   assign bus.phase    = phase_q;
   assign bus.wbEnable = wb_enable;
   assign bus.wbAddr   = wb_addr;
   assign bus.wbData   = wb_data;
   assign bus.fwdValid = fwd_valid;
   assign bus.fwdAddr  = fwd_addr;
   assign bus.fwdData  = fwd_data;
   assign bus.retired  = retired_count;

endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: self-checking bench for writeback_stage.
// Instructions are driven one at a time; inputs carry random junk except in the
// capture cycle. The expected state is an instruction-level record updated once
// per completed instruction and compared against the outputs every cycle.
module tb_writeback_stage;
   logic clock;
   logic reset;
   int   errors;
   int   checks;

   // Instruction-level expectation of the visible state.
   logic        m_en;
   logic [4:0]  m_addr;
   logic [31:0] m_data;
   logic        m_fv;
   logic [4:0]  m_fa;
   logic [31:0] m_fd;
   logic [31:0] m_ret;

   writeback_stage_if bus ();

   writeback_stage #(
      .PHASES(10),
      .CAPTURE_PHASE(8),
      .COMMIT_PHASE(9)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus(bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_en = 1'b0; m_addr = '0; m_data = '0;
      m_fv = 1'b0; m_fa = '0; m_fd = '0; m_ret = '0;
   endtask

   task automatic check_all(input int p);
      chk("phase",    32'(bus.phase), 32'(p));
      chk("wbEnable", 32'(bus.wbEnable), (p == 0) ? 32'(m_en) : 32'd0);
      chk("wbAddr",   32'(bus.wbAddr), 32'(m_addr));
      chk("wbData",   bus.wbData, m_data);
      chk("fwdValid", 32'(bus.fwdValid), 32'(m_fv));
      chk("fwdAddr",  32'(bus.fwdAddr), 32'(m_fa));
      chk("fwdData",  bus.fwdData, m_fd);
      chk("retired",  bus.retired, m_ret);
   endtask

   task automatic drive_junk();
      bus.regWrite    = 1'($urandom);
      bus.memToReg    = 2'($urandom);
      bus.aluResult   = $urandom;
      bus.memReadData = $urandom;
      bus.pcPlus4     = $urandom;
      bus.rd          = 5'($urandom);
   endtask

   // Entered and left at the falling edge of a phase-0 cycle. With abort set,
   // reset is pulled low during the capture cycle and the task returns at the
   // falling edge after the resetting edge, reset still low.
   task automatic run_instr(input logic rw, input logic [1:0] sel, input logic [31:0] alu,
                            input logic [31:0] mem, input logic [31:0] pc,
                            input logic [4:0] rdv, input bit abort);
      logic [31:0] src;
      logic        wr;
      for (int p = 0; p < 10; p++) begin
         check_all(p);
         if (p == 8) begin
            bus.regWrite = rw; bus.memToReg = sel; bus.aluResult = alu;
            bus.memReadData = mem; bus.pcPlus4 = pc; bus.rd = rdv;
         end else begin
            drive_junk();
         end
         if (abort && p == 8) begin
            reset = 1'b0;
            @(negedge clock);
            model_reset();
            return;
         end
         @(negedge clock);
      end
      src = (sel == 2'b01) ? mem : (sel == 2'b10) ? pc : alu;
      wr  = rw && (rdv != 5'd0);
      m_ret  = m_ret + 32'd1;
      m_en   = wr;
      m_addr = rdv;
      m_data = src;
      m_fv   = wr;
      if (wr) begin
         m_fa = rdv;
         m_fd = src;
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      model_reset();
      reset = 1'b0;
      drive_junk();
      repeat (3) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;

      // ALU source to rd=5.
      run_instr(1'b1, 2'b00, 32'h0000_002A, 32'h0, 32'h0, 5'd5, 1'b0);
      // Source select sweep.
      run_instr(1'b1, 2'b01, 32'h11, 32'hDEAD_BEEF, 32'h104, 5'd9, 1'b0);
      run_instr(1'b1, 2'b10, 32'h11, 32'hDEAD_BEEF, 32'h104, 5'd10, 1'b0);
      run_instr(1'b1, 2'b11, 32'h11, 32'hDEAD_BEEF, 32'h104, 5'd11, 1'b0);
      // Write to x0 suppressed, forwarding record held.
      run_instr(1'b1, 2'b00, 32'h55, 32'h0, 32'h0, 5'd0, 1'b0);
      // regWrite low still retires.
      run_instr(1'b0, 2'b00, 32'h77, 32'h0, 32'h0, 5'd3, 1'b0);
      // Captured value wins over later input changes (junk driven at phase 9).
      run_instr(1'b1, 2'b00, 32'h1, 32'h0, 32'h0, 5'd4, 1'b0);
      run_instr(1'b1, 2'b00, 32'h2, 32'h0, 32'h0, 5'd6, 1'b0);

      // Reset during the capture cycle aborts the instruction.
      run_instr(1'b1, 2'b00, 32'hABCD, 32'h0, 32'h0, 5'd7, 1'b1);
      check_all(0);
      reset = 1'b1;
      run_instr(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);

      // Retired counter wrap.
      force dut.retired_count = 32'hFFFF_FFFF;
      #1;
      release dut.retired_count;
      m_ret = 32'hFFFF_FFFF;
      run_instr(1'b1, 2'b01, 32'h0, 32'h1234_5678, 32'h0, 5'd12, 1'b0);

      // Random instructions.
      for (int i = 0; i < 40; i++) begin
         logic [4:0] r;
         r = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
         run_instr(1'($urandom), 2'($urandom), $urandom, $urandom, $urandom, r, 1'b0);
      end
      check_all(0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
